// File: rtl/aes_kat_pkg.sv
// Shared FIPS-197 Appendix C vectors, encodings and FSM types
// for the AES known-answer-test sequencer.
package aes_kat_pkg;

  localparam logic [127:0] PT =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128 =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192 =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 =
    128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 =
    128'h8ea2b7ca516745bfea9afc49904b4960;

  localparam logic [1:0] KL_128 = 2'd0;
  localparam logic [1:0] KL_192 = 2'd1;
  localparam logic [1:0] KL_256 = 2'd2;

  localparam logic [2:0] T_E128 = 3'd0;
  localparam logic [2:0] T_D128 = 3'd1;
  localparam logic [2:0] T_E192 = 3'd2;
  localparam logic [2:0] T_D192 = 3'd3;
  localparam logic [2:0] T_E256 = 3'd4;
  localparam logic [2:0] T_D256 = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic         decrypt;
    logic [1:0]   keylen;
    logic [255:0] key;
    logic [127:0] din;
    logic [127:0] expected;
  } vec_t;

endpackage

// File: rtl/aes_kat_if.sv
// Request/response bundle between the KAT sequencer
// and the shared round-iterative AES core.
interface aes_kat_if;

  logic         start;
  logic         decrypt;
  logic [1:0]   keylen;
  logic [255:0] key;
  logic [127:0] din;
  logic [127:0] dout;
  logic         done;

  modport master (
    output start,
    output decrypt,
    output keylen,
    output key,
    output din,
    input  dout,
    input  done
  );

  modport slave (
    input  start,
    input  decrypt,
    input  keylen,
    input  key,
    input  din,
    output dout,
    output done
  );

endinterface

// File: rtl/aes_kat_rom.sv
// Test index to vector lookup; keys are left-justified
// in the 256-bit key field with zeroed LSBs.
module aes_kat_rom
  import aes_kat_pkg::*;
(
  input  logic [2:0] idx,
  output vec_t       vec
);

  always_comb begin
    vec = '0;
    case (idx)
      T_E128: vec = '{1'b0, KL_128, {K128, 128'h0}, PT, CT128};
      T_D128: vec = '{1'b1, KL_128, {K128, 128'h0}, CT128, PT};
      T_E192: vec = '{1'b0, KL_192, {K192, 64'h0}, PT, CT192};
      T_D192: vec = '{1'b1, KL_192, {K192, 64'h0}, CT192, PT};
      T_E256: vec = '{1'b0, KL_256, K256, PT, CT256};
      T_D256: vec = '{1'b1, KL_256, K256, CT256, PT};
      default: vec = '0;
    endcase
  end

endmodule

// File: rtl/aes_kat_sequencer.sv
// Sequenced known-answer test: runs six AES vectors through
// the shared core and drives per-test pass LEDs.
module aes_kat_sequencer
  import aes_kat_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      enable,
  aes_kat_if.master core,
  output logic      e128,
  output logic      d128,
  output logic      e192,
  output logic      d192,
  output logic      e256,
  output logic      d256,
  output logic      busy,
  output logic      all_pass
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_d;
  logic             en_q;
  logic             rise;
  logic [2:0]       idx, idx_d;
  logic [5:0]       res, res_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [127:0]     cap;
  logic [127:0]     exp_q;
  logic             load;
  logic             cap_en;
  logic [2:0]       rom_idx;
  vec_t             vec;
  logic             show;

  assign rise = enable & ~en_q;

  assign busy = (state == S_ISSUE) || (state == S_WAIT) ||
                (state == S_CHECK) || (state == S_NEXT);

  // Vectors are only ever loaded for test 0 or the one after idx
  assign rom_idx = (state == S_NEXT) ? idx + 3'd1 : 3'd0;

  aes_kat_rom u_rom (
    .idx (rom_idx),
    .vec (vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      en_q  <= 1'b0;
      idx   <= '0;
      res   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      en_q  <= enable;
      idx   <= idx_d;
      res   <= res_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    res_d   = res;
    cnt_d   = cnt;
    load    = 1'b0;
    cap_en  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (rise) begin
          res_d   = '0;
          idx_d   = '0;
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core.done) begin
          cap_en  = 1'b1;
          state_d = S_CHECK;
        end else if (cnt == CNT_LAST) begin
          res_d[idx] = 1'b0;
          state_d    = S_NEXT;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_CHECK: begin
        res_d[idx] = (cap == exp_q);
        state_d    = S_NEXT;
      end
      S_NEXT: begin
        if (idx == T_D256) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx + 3'd1;
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Dropping enable mid-run abandons the sequence outright
    if (busy && !enable) begin
      state_d = S_IDLE;
      res_d   = '0;
      load    = 1'b0;
      cap_en  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core.decrypt <= 1'b0;
      core.keylen  <= '0;
      core.key     <= '0;
      core.din     <= '0;
      exp_q        <= '0;
    end else if (load) begin
      core.decrypt <= vec.decrypt;
      core.keylen  <= vec.keylen;
      core.key     <= vec.key;
      core.din     <= vec.din;
      exp_q        <= vec.expected;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap <= '0;
    end else if (cap_en) begin
      cap <= core.dout;
    end
  end

  assign core.start = (state == S_ISSUE) && enable;

  assign show     = enable && (state == S_DONE);
  assign e128     = res[0] & show;
  assign d128     = res[1] & show;
  assign e192     = res[2] & show;
  assign d192     = res[3] & show;
  assign e256     = res[4] & show;
  assign d256     = res[5] & show;
  assign all_pass = (&res) & show;

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Directed bench for the AES KAT sequencer with a
// fixed-latency vector-answering core model.
module tb_aes_kat_sequencer;

  localparam int L = 12;

  localparam logic [127:0] TPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] TC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] TC2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] TC3  = 128'h8ea2b7ca516745bfea9afc49904b4960;
  localparam logic [255:0] TK1  =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] TK2  =
    {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] TK3  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic e128, d128, e192, d192, e256, d256;
  logic busy, all_pass;
  logic [5:0] leds;

  aes_kat_if cif ();

  aes_kat_sequencer #(
    .TIMEOUT_CYCLES (64),
    .CNT_W          (7)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .core     (cif),
    .e128     (e128),
    .d128     (d128),
    .e192     (e192),
    .d192     (d192),
    .e256     (e256),
    .d256     (d256),
    .busy     (busy),
    .all_pass (all_pass)
  );

  always #5 clk = ~clk;

  assign leds = {d256, e256, d192, e192, d128, e128};

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Answers correctly only when key/din match a known vector
  function automatic logic [127:0] ref_out(input logic dec,
                                           input logic [1:0] kl,
                                           input logic [255:0] key,
                                           input logic [127:0] din);
    logic [255:0] k;
    logic [127:0] ct;
    case (kl)
      2'd0: begin k = TK1; ct = TC1; end
      2'd1: begin k = TK2; ct = TC2; end
      2'd2: begin k = TK3; ct = TC3; end
      default: return '1;
    endcase
    if (key !== k) return '1;
    if (!dec) return (din === TPT) ? ct : '1;
    return (din === ct) ? TPT : '1;
  endfunction

  int corrupt_id = -1;
  int hang_id = -1;
  logic spur = 1'b0;
  logic pend;
  int k;
  int cur_id;
  logic [127:0] ans;
  logic [255:0] snap_key;
  logic [127:0] snap_din;
  logic snap_dec;
  logic [1:0] snap_kl;
  int unstable = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      k        <= 0;
      cif.done <= 1'b0;
      cif.dout <= '0;
    end else begin
      cif.done <= spur;
      if (cif.start) begin
        pend     <= 1'b1;
        k        <= 1;
        cur_id   <= int'({cif.keylen, cif.decrypt});
        ans      <= ref_out(cif.decrypt, cif.keylen, cif.key, cif.din) ^
                    ((int'({cif.keylen, cif.decrypt}) == corrupt_id) ?
                     128'h1 : 128'h0);
        snap_key <= cif.key;
        snap_din <= cif.din;
        snap_dec <= cif.decrypt;
        snap_kl  <= cif.keylen;
      end else if (pend) begin
        if (cif.key !== snap_key || cif.din !== snap_din ||
            cif.decrypt !== snap_dec || cif.keylen !== snap_kl)
          unstable <= unstable + 1;
        if (cur_id != hang_id && k + 1 == L) begin
          cif.done <= 1'b1;
          cif.dout <= ans;
          pend     <= 1'b0;
        end
        k <= k + 1;
      end
    end
  end

  int nstart = 0;
  int nbusy = 0;
  int klog[64];
  int dlog[64];

  always @(posedge clk) begin
    if (cif.start) begin
      if (nstart < 64) begin
        klog[nstart] <= int'(cif.keylen);
        dlog[nstart] <= int'(cif.decrypt);
      end
      nstart <= nstart + 1;
    end
    if (busy) nbusy <= nbusy + 1;
  end

  int s0, b0;
  int exp_kl[6] = '{0, 0, 1, 1, 2, 2};
  int exp_dc[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    // Reset with enable already high
    enable = 1'b1;
    rst_n  = 1'b0;
    cycles(2);
    chk("rst_busy", busy, 0);
    chk("rst_leds", leds, 0);
    chk("rst_allpass", all_pass, 0);
    chk("rst_start", cif.start, 0);
    chk("rst_key", cif.key, 0);
    chk("rst_din", cif.din, 0);
    chk("rst_kl", cif.keylen, 0);

    // 1: full clean run from reset
    s0 = nstart;
    b0 = nbusy;
    rst_n = 1'b1;
    cycles(20);
    chk("run_busy", busy, 1);
    chk("run_leds_off", leds, 0);
    cycles(100);
    chk("t1_busy_cycles", nbusy - b0, 90);
    chk("t1_starts", nstart - s0, 6);
    for (int i = 0; i < 6; i++) begin
      chk("t1_keylen", klog[s0 + i], exp_kl[i]);
      chk("t1_decrypt", dlog[s0 + i], exp_dc[i]);
    end
    chk("t1_leds", leds, 6'h3f);
    chk("t1_allpass", all_pass, 1);
    chk("t1_idle", busy, 0);

    // 2: corrupted d192 answer
    corrupt_id = 3;
    enable = 1'b0;
    cycles(2);
    chk("done_en_low_leds", leds, 0);
    chk("done_en_low_ap", all_pass, 0);
    enable = 1'b1;
    s0 = nstart;
    cycles(120);
    chk("t2_leds", leds, 6'b110111);
    chk("t2_allpass", all_pass, 0);
    chk("t2_starts", nstart - s0, 6);

    // 3: core never answers e192
    corrupt_id = -1;
    hang_id = 2;
    enable = 1'b0;
    cycles(2);
    enable = 1'b1;
    s0 = nstart;
    b0 = nbusy;
    cycles(200);
    chk("t3_leds", leds, 6'b111011);
    chk("t3_allpass", all_pass, 0);
    chk("t3_starts", nstart - s0, 6);
    chk("t3_busy_cycles", nbusy - b0, 141);

    // 4: clean run, disable in DONE, then rerun
    hang_id = -1;
    enable = 1'b0;
    cycles(2);
    enable = 1'b1;
    cycles(120);
    chk("t4_pre_leds", leds, 6'h3f);
    enable = 1'b0;
    s0 = nstart;
    cycles(10);
    chk("t4_off_leds", leds, 0);
    chk("t4_off_ap", all_pass, 0);
    chk("t4_off_starts", nstart - s0, 0);
    enable = 1'b1;
    cycles(120);
    chk("t4_re_starts", nstart - s0, 6);
    chk("t4_re_leds", leds, 6'h3f);
    chk("t4_re_ap", all_pass, 1);

    // 5: abort during WAIT of d192
    enable = 1'b0;
    cycles(2);
    enable = 1'b1;
    s0 = nstart;
    for (int i = 0; i < 200 && nstart - s0 < 4; i++) @(negedge clk);
    chk("t5_reach_d192", nstart - s0, 4);
    chk("t5_d192_kl", klog[s0 + 3], 1);
    cycles(3);
    chk("t5_in_wait", busy, 1);
    enable = 1'b0;
    cycles(1);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_leds", leds, 0);
    cycles(30);
    chk("t5_no_starts", nstart - s0, 4);
    chk("t5_still_idle", busy, 0);
    enable = 1'b1;
    s0 = nstart;
    for (int i = 0; i < 10 && nstart == s0; i++) @(negedge clk);
    chk("t5_restart", nstart - s0, 1);
    chk("t5_restart_kl", klog[s0], 0);
    chk("t5_restart_dec", dlog[s0], 0);
    cycles(120);
    chk("t5_leds", leds, 6'h3f);

    // 6: async reset mid-WAIT, then spurious done in IDLE
    enable = 1'b0;
    cycles(2);
    enable = 1'b1;
    s0 = nstart;
    for (int i = 0; i < 10 && nstart == s0; i++) @(negedge clk);
    cycles(3);
    chk("t6_pre_busy", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_start", cif.start, 0);
    chk("t6_key", cif.key, 0);
    chk("t6_din", cif.din, 0);
    chk("t6_kl", cif.keylen, 0);
    chk("t6_dec", cif.decrypt, 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    s0 = nstart;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    cycles(3);
    chk("t6_spur_busy", busy, 0);
    chk("t6_spur_starts", nstart - s0, 0);
    chk("t6_spur_leds", leds, 0);
    enable = 1'b1;
    cycles(120);
    chk("t6_after_leds", leds, 6'h3f);
    chk("t6_after_ap", all_pass, 1);

    chk("key_din_stable", unstable, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
